// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: FSM state encoding, oversampling
//            constants and frame-format defaults used by the transmitter,
//            receiver and baud-rate generator.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // 16 sample_ticks per bit; MID_TICK is the last tick before the bit centre
  localparam int OVERSAMPLE  = 16;
  localparam int MID_TICK    = 7;

  // Frame-format defaults shared across the UART blocks (8N1)
  localparam int DEF_DBITS   = 8;
  localparam int DEF_SB_TICK = 16;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchroniser for the asynchronous rx line. Both flops
//            reset to 1 so the receiver sees an idle line out of reset.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronisation; reset value models an idle (high) line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 16x-oversampled UART receive path. Validates the start bit at
//            mid-bit, samples data bits LSB first at mid-bit, checks the stop
//            bit and emits a one-cycle rx_done / frame_err pulse with the word.
// Revision : 1.0  initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBITS   = DEF_DBITS,   // 1..8 data bits
  parameter int SB_TICK = DEF_SB_TICK  // 16 = 1 stop bit, 32 = 2 stop bits
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam logic [4:0] C_MID_TICK  = 5'(MID_TICK);
  localparam logic [4:0] C_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] C_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] C_NBITS_END = 3'(DBITS - 1);

  logic             rx_s;

  rx_state_t        state_q, state_d;
  logic [4:0]       tick_q,  tick_d;
  logic [2:0]       nbits_q, nbits_d;
  logic [DBITS-1:0] data_q,  data_d;
  logic [DBITS-1:0] dout_q,  dout_d;
  logic             done_q,  done_d;
  logic             ferr_q,  ferr_d;
  // Cleared when a frame ends on a low line (break); a high line must be
  // seen before a new start edge is accepted, so a held-low line yields
  // exactly one frame instead of a stream of 0x00 frames.
  logic             armed_q, armed_d;

  uart_rx_sync u_sync (
    .clk_i (clk_100MHz),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      nbits_q <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      nbits_q <= nbits_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic: counters only advance on sample_tick, except the
  // IDLE->START edge which reacts to rx_s immediately and ignores any
  // coincident tick (tick restarts at 0).
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    nbits_d = nbits_q;
    data_d  = data_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;

    unique case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (tick_q == C_MID_TICK) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              nbits_d = '0;
            end else begin
              // line went back high before mid-bit: glitch, not a start bit
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (tick_q == C_BIT_LAST) begin
            tick_d = '0;
            // shift in LSB first; shift form stays legal for DBITS == 1
            data_d = (data_q >> 1) | (DBITS'(rx_s) << (DBITS - 1));
            if (nbits_q == C_NBITS_END) begin
              state_d = STOP;
            end else begin
              nbits_d = nbits_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (tick_q == C_STOP_LAST) begin
            // stop sampled at its centre; leaving now re-arms half a bit
            // early so back-to-back frames survive clock skew
            tick_d  = '0;
            state_d = IDLE;
            dout_d  = data_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
            armed_d = rx_s;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign data_out  = dout_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule : uart_receiver
`default_nettype wire
